clk_en_sequencer: RTL and testbench

CLK_EN_SEQUENCER -- requirements
Module: clk_en_sequencer

---
 rtl/clk_en_sequencer.sv | 159 +++++++++++++++
 tb/tb_clk_en_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_sequencer.sv
// clk_en_sequencer: holds a downstream core in reset for HOLD_CYCLES clocks,
// then produces per-channel clock-enable pulses with programmable divisors.
// Optional feature macro: CLK_EN_SQUARE_OUT_EN adds per-channel square-wave
// outputs on sq; without it sq is tied low and no toggle flops exist.
module clk_en_sequencer #(
    parameter int                          NUM_CH      = 3,
    parameter int                          DIV_W       = 4,
    parameter int                          HOLD_CYCLES = 8,
    parameter logic [NUM_CH*DIV_W-1:0]     DIV_INIT    = {4'd7, 4'd3, 4'd1}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    input  logic              cfg_load,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic              core_rst,
    output logic              ready,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] sq
);

    localparam int              HC_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]      NUM_CH_L  = 4'(NUM_CH);

    typedef enum logic {
        S_HOLD,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HC_W-1:0]   hold_cnt;
    logic [HC_W-1:0]   hold_cnt_nxt;
    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    // Marks the cycle right after a divisor write so that channel stays quiet.
    logic [NUM_CH-1:0] load_mask;
    logic              cfg_valid;
    logic [NUM_CH-1:0] ch_sel;

    assign cfg_valid = ({1'b0, cfg_ch} < NUM_CH_L);

    // Decode which channel (if any) a valid divisor write targets.
    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            ch_sel[i] = cfg_load && cfg_valid && (cfg_ch == 3'(i));
    end

    // State register and hold counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!rst) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state logic: count out the hold, leave on the last count, and
    // restart the hold on any software reset request.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            S_HOLD: begin
                if (sw_rst_req) begin
                    hold_cnt_nxt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt    = S_RUN;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + HC_W'(1);
                end
            end
            S_RUN: begin
                if (sw_rst_req) begin
                    state_nxt    = S_HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = S_HOLD;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    // Per-channel divisor registers, divide counters, write mask and cfg_err.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the divisor array is a handful of flops with defined boot
            // values, so it is reset explicitly rather than left uninitialised.
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
                cnt_q[i] <= '0;
            end
            load_mask <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err   <= cfg_load && !cfg_valid;
            load_mask <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel[i]) begin
                    div_q[i]     <= cfg_div;
                    cnt_q[i]     <= '0;
                    load_mask[i] <= 1'b1;
                end else if (state != S_RUN || state_nxt != S_RUN) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == div_q[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DIV_W'(1);
                end
            end
        end
    end

    // Enable pulses decoded purely from registered state.
    always_comb begin
        ce = '0;
        for (int i = 0; i < NUM_CH; i++)
            ce[i] = (state == S_RUN) && (cnt_q[i] == div_q[i]) && !load_mask[i];
    end

    assign core_rst = (state == S_HOLD);
    assign ready    = ~core_rst;

`ifdef CLK_EN_SQUARE_OUT_EN
    logic [NUM_CH-1:0] sq_q;

    // Square wave: toggle after the mid-point count and after each enable,
    // cleared while held and whenever the channel is reprogrammed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sq_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel[i] || state != S_RUN || state_nxt != S_RUN)
                    sq_q[i] <= 1'b0;
                else if (ce[i] || (cnt_q[i] == (div_q[i] >> 1) && cnt_q[i] != div_q[i]))
                    sq_q[i] <= ~sq_q[i];
            end
        end
    end

    assign sq = sq_q;
`else
    assign sq = '0;
`endif

endmodule

// File: tb/tb_clk_en_sequencer.sv
// Self-checking bench for clk_en_sequencer: a cycle-level model built from
// elapsed-cycle arithmetic, compared every cycle, plus literal expectations.
module tb_clk_en_sequencer;

    localparam int                      NUM_CH      = 3;
    localparam int                      DIV_W       = 4;
    localparam int                      HOLD_CYCLES = 8;
    localparam logic [NUM_CH*DIV_W-1:0] DIV_INIT    = {4'd7, 4'd3, 4'd1};

    logic              clk;
    logic              rst;
    logic              sw_rst_req;
    logic              cfg_load;
    logic [2:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_err;
    logic              core_rst;
    logic              ready;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] sq;

    int checks = 0;
    int errors = 0;

    // Literal enable rows {ce2,ce1,ce0} for run cycles 0..7 with divisors 1/3/7.
    logic [2:0] ce_boot [8] = '{3'b000, 3'b001, 3'b000, 3'b011,
                                3'b000, 3'b001, 3'b000, 3'b111};
    // Rows after sw reset with divisors 1/0/1.
    logic [2:0] ce_swr  [4] = '{3'b010, 3'b111, 3'b010, 3'b111};
`ifdef CLK_EN_SQUARE_OUT_EN
    logic [7:0] sq2_boot = 8'b1111_0000;
`else
    logic [7:0] sq2_boot = 8'b0000_0000;
`endif

    clk_en_sequencer #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .DIV_INIT    (DIV_INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .cfg_load   (cfg_load),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_err    (cfg_err),
        .core_rst   (core_rst),
        .ready      (ready),
        .ce         (ce),
        .sq         (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t counts cycles since the channel's counting origin (RUN entry or a
    // write); enables fall where (t+1) is a multiple of (div+1).
    bit m_valid = 1'b0;
    bit m_run;
    int m_hold;
    bit m_err;
    int m_div   [NUM_CH];
    int m_t     [NUM_CH];
    bit m_fresh [NUM_CH];
    bit m_par   [NUM_CH];

    function automatic bit run_after();
        if (sw_rst_req) return 1'b0;
        if (m_run) return 1'b1;
        return (m_hold + 1 >= HOLD_CYCLES);
    endfunction

    function automatic bit ce_bit(int i);
        return m_run && !m_fresh[i] && ((m_t[i] + 1) % (m_div[i] + 1) == 0);
    endfunction

    function automatic bit sq_bit(int i);
`ifdef CLK_EN_SQUARE_OUT_EN
        if (!m_run) return 1'b0;
        if (m_div[i] == 0) return m_par[i];
        return (m_t[i] % (m_div[i] + 1)) > (m_div[i] / 2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [NUM_CH-1:0] ce_model();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i] = ce_bit(i);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] sq_model();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i] = sq_bit(i);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_valid <= 1'b1;
            m_run   <= 1'b0;
            m_hold  <= 0;
            m_err   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i]   <= int'(DIV_INIT[i*DIV_W +: DIV_W]);
                m_t[i]     <= 0;
                m_fresh[i] <= 1'b0;
                m_par[i]   <= 1'b0;
            end
        end else begin
            m_err  <= cfg_load && (int'(cfg_ch) >= NUM_CH);
            m_run  <= run_after();
            m_hold <= (sw_rst_req || m_run) ? 0 : m_hold + 1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_load && int'(cfg_ch) == i) begin
                    m_div[i]   <= int'(cfg_div);
                    m_t[i]     <= 0;
                    m_fresh[i] <= 1'b1;
                    m_par[i]   <= 1'b0;
                end else begin
                    m_fresh[i] <= 1'b0;
                    if (m_run && run_after()) begin
                        m_t[i]   <= m_t[i] + 1;
                        m_par[i] <= m_par[i] ^ ce_bit(i);
                    end else begin
                        m_t[i]   <= 0;
                        m_par[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("core_rst", 32'(core_rst), 32'(!m_run));
            check("ready",    32'(ready),    32'(m_run));
            check("cfg_err",  32'(cfg_err),  32'(m_err));
            check("ce",       32'(ce),       32'(ce_model()));
            check("sq",       32'(sq),       32'(sq_model()));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_release(output int n);
        n = 0;
        while (core_rst !== 1'b0 && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_hold(output int n);
        n = 0;
        while (core_rst === 1'b1 && n < 50) begin
            check("hold_ce", 32'(ce), 32'(0));
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_boot_rows(input string tag);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_ce[%0d]", tag, k), 32'(ce), 32'(ce_boot[k]));
            check($sformatf("%s_sq2[%0d]", tag, k), 32'(sq[2]), 32'(sq2_boot[k]));
            if (k < 7) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; sw_rst_req = 1'b0; cfg_load = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (3) @(negedge clk);
        check("reset_core_rst", 32'(core_rst), 32'(1));
        check("reset_ce", 32'(ce), 32'(0));
        rst = 1'b1;
        wait_release(n);
        check("release_edges", 32'(n), 32'(8));
        check_boot_rows("boot");

        // Reprogram channel 1 to divide-by-1 while running.
        cfg_load = 1'b1; cfg_ch = 3'd1; cfg_div = 4'd0;
        @(negedge clk);
        cfg_load = 1'b0;
        check("load_quiet_ce1", 32'(ce[1]), 32'(0));
        @(negedge clk);
        check("load_ce1_a", 32'(ce[1]), 32'(1));
        @(negedge clk);
        check("load_ce1_b", 32'(ce[1]), 32'(1));
        repeat (6) @(negedge clk);

        // Out-of-range channel write.
        cfg_load = 1'b1; cfg_ch = 3'd5; cfg_div = 4'd2;
        @(negedge clk);
        cfg_load = 1'b0;
        check("err_pulse", 32'(cfg_err), 32'(1));
        @(negedge clk);
        check("err_clear", 32'(cfg_err), 32'(0));
        repeat (9) @(negedge clk);

        // Software reset together with a write to channel 2.
        sw_rst_req = 1'b1; cfg_load = 1'b1; cfg_ch = 3'd2; cfg_div = 4'd1;
        @(negedge clk);
        sw_rst_req = 1'b0; cfg_load = 1'b0;
        count_hold(n);
        check("swr_hold_cycles", 32'(n), 32'(8));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("swr_ce[%0d]", k), 32'(ce), 32'(ce_swr[k]));
            @(negedge clk);
        end
        repeat (5) @(negedge clk);

        // Software reset repeated inside the hold restarts the count.
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        repeat (2) @(negedge clk);
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        count_hold(n);
        check("restart_hold_cycles", 32'(n), 32'(8));
        repeat (6) @(negedge clk);

        // Hard reset mid-run wins over simultaneous write and sw request.
        rst = 1'b0; sw_rst_req = 1'b1; cfg_load = 1'b1; cfg_ch = 3'd0; cfg_div = 4'd5;
        @(negedge clk);
        sw_rst_req = 1'b0; cfg_load = 1'b0;
        check("hard_ce",       32'(ce),       32'(0));
        check("hard_core_rst", 32'(core_rst), 32'(1));
        check("hard_ready",    32'(ready),    32'(0));
        check("hard_sq",       32'(sq),       32'(0));
        check("hard_cfg_err",  32'(cfg_err),  32'(0));
        @(negedge clk);
        rst = 1'b1;
        wait_release(n);
        check("rerelease_edges", 32'(n), 32'(8));
        check_boot_rows("reboot");
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
